// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^M) log/antilog engine: op encodings,
// default primitive polynomials and elaboration-time table generators.
// Optional feature macro: GF_INV_EN (adds the 1/B operation, widens op to 2 bits).
package gf_pkg;

`ifdef GF_INV_EN
    localparam int unsigned GF_OP_W = 2;
`else
    localparam int unsigned GF_OP_W = 1;
`endif

    typedef logic [GF_OP_W-1:0] gf_op_t;

    localparam gf_op_t GF_OP_MUL = gf_op_t'(0);
    localparam gf_op_t GF_OP_DIV = gf_op_t'(1);
`ifdef GF_INV_EN
    localparam gf_op_t GF_OP_INV = gf_op_t'(2);
`endif

    localparam logic [4:0]  GF_POLY_M4  = 5'h13;
    localparam logic [8:0]  GF_POLY_M8  = 9'h11D;
    localparam logic [10:0] GF_POLY_M10 = 11'h409;

    // Default primitive polynomial for the widths we ship; 0 means "supply one"
    function automatic int unsigned gf_default_poly(input int unsigned m);
        case (m)
            4:       return 32'(GF_POLY_M4);
            8:       return 32'(GF_POLY_M8);
            10:      return 32'(GF_POLY_M10);
            default: return 0;
        endcase
    endfunction

    // Multiply a field element by alpha = x, reducing by poly
    function automatic int unsigned gf_step(input int unsigned m, input int unsigned poly,
                                            input int unsigned p);
        int unsigned q;
        q = p << 1;
        if (((q >> m) & 1) != 0) q = q ^ poly;
        return q;
    endfunction

    // exp table entry: alpha^idx in polynomial form
    function automatic int unsigned gf_exp_table(input int unsigned m, input int unsigned poly,
                                                 input int unsigned idx);
        int unsigned p;
        p = 1;
        for (int unsigned k = 0; k < idx; k++) p = gf_step(m, poly, p);
        return p;
    endfunction

    // log table entry: k with alpha^k == val; 0 for val == 0 (don't-care)
    function automatic int unsigned gf_log_table(input int unsigned m, input int unsigned poly,
                                                 input int unsigned val);
        int unsigned p;
        p = 1;
        for (int unsigned k = 0; k < (1 << m) - 1; k++) begin
            if (p == val) return k;
            p = gf_step(m, poly, p);
        end
        return 0;
    endfunction

    // Multiplicative order of alpha; equals 2^m-1 exactly when poly is primitive
    function automatic int unsigned gf_order(input int unsigned m, input int unsigned poly);
        int unsigned p;
        p = 1;
        for (int unsigned k = 1; k <= (1 << m) - 1; k++) begin
            p = gf_step(m, poly, p);
            if (p == 1) return k;
        end
        return 0;
    endfunction

endpackage

// File: rtl/gf_logexp_rom.sv
// Combinational log or exp lookup for GF(2^M); table contents are constants
// computed from POLY at elaboration.
module gf_logexp_rom
    import gf_pkg::*;
#(
    parameter int unsigned M      = 8,
    parameter logic [M:0]  POLY   = (M+1)'(gf_default_poly(M)),
    parameter bit          IS_EXP = 1'b0
) (
    input  logic [M-1:0] addr,
    output logic [M-1:0] data
);

    localparam int unsigned SIZE = 1 << M;
    localparam int unsigned N    = SIZE - 1;
    localparam int unsigned ORD  = gf_order(M, 32'(POLY));

    logic [M-1:0] tab [SIZE];

    for (genvar i = 0; i < SIZE; i++) begin : g_tab
        if (IS_EXP) begin : g_exp
            localparam logic [M-1:0] V = M'(gf_exp_table(M, 32'(POLY), 32'(i)));
            assign tab[i] = V;
        end else begin : g_log
            localparam logic [M-1:0] V = M'(gf_log_table(M, 32'(POLY), 32'(i)));
            assign tab[i] = V;
        end
    end

    assign data = tab[addr];

    // Simulation check: exp must cycle through all N non-zero elements
    always_comb begin : p_poly_chk
        assert (ORD == N);
    end

endmodule

// File: rtl/gf_logmul_pipe.sv
// Three-stage GF(2^M) multiply/divide pipeline using log/antilog lookups,
// valid/ready flow control with collapsing bubbles and tag pass-through.
// Optional feature macro: GF_INV_EN (in_op = 2 computes 1/B).
module gf_logmul_pipe
    import gf_pkg::*;
#(
    parameter int unsigned M     = 8,
    parameter logic [M:0]  POLY  = (M+1)'(gf_default_poly(M)),
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    input  gf_op_t           in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    logic [M-1:0]     log_a, log_b, exp_q;
    logic             ld1, ld2, ld3;

    logic             s1_valid, s1_za, s1_zb;
    logic [M-1:0]     s1_la, s1_lb;
    gf_op_t           s1_op;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid, s2_za, s2_zb;
    logic [M-1:0]     s2_e;
    gf_op_t           s2_op;
    logic [TAG_W-1:0] s2_tag;

    logic [M-1:0]     e_nxt, sum_lo, dif_lo, res_data;
    logic             sum_c, dif_b, res_err;

    gf_logexp_rom #(.M(M), .POLY(POLY), .IS_EXP(1'b0)) u_log_a (.addr(in_a), .data(log_a));
    gf_logexp_rom #(.M(M), .POLY(POLY), .IS_EXP(1'b0)) u_log_b (.addr(in_b), .data(log_b));
    gf_logexp_rom #(.M(M), .POLY(POLY), .IS_EXP(1'b1)) u_exp   (.addr(s2_e), .data(exp_q));

    // Stage load enables: a stage loads when empty or when its successor loads
    always_comb begin
        ld3 = !out_valid || out_ready;
        ld2 = !s2_valid || ld3;
        ld1 = !s1_valid || ld2;
    end

    assign in_ready = ld1;

    // Stage 1: operand logs, zero flags, op and tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_la    <= '0;
            s1_lb    <= '0;
            s1_za    <= 1'b0;
            s1_zb    <= 1'b0;
            s1_op    <= GF_OP_MUL;
            s1_tag   <= '0;
        end else if (ld1) begin
            s1_valid <= in_valid;
            s1_la    <= log_a;
            s1_lb    <= log_b;
            s1_za    <= (in_a == '0);
            s1_zb    <= (in_b == '0);
            s1_op    <= in_op;
            s1_tag   <= in_tag;
        end
    end

    // Exponent arithmetic mod N; N is all-ones in M bits, so -N == +1 and +N == -1
    always_comb begin
        {sum_c, sum_lo} = {1'b0, s1_la} + {1'b0, s1_lb};
        {dif_b, dif_lo} = {1'b0, s1_la} - {1'b0, s1_lb};
        if (sum_c || (sum_lo == '1)) sum_lo = sum_lo + M'(1);
        if (dif_b) dif_lo = dif_lo - M'(1);
        case (s1_op)
            GF_OP_DIV: e_nxt = dif_lo;
`ifdef GF_INV_EN
            GF_OP_INV: e_nxt = (s1_lb == '0) ? '0 : ~s1_lb;
`endif
            default:   e_nxt = sum_lo;
        endcase
    end

    // Stage 2: reduced exponent plus flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_e     <= '0;
            s2_za    <= 1'b0;
            s2_zb    <= 1'b0;
            s2_op    <= GF_OP_MUL;
            s2_tag   <= '0;
        end else if (ld2) begin
            s2_valid <= s1_valid;
            s2_e     <= e_nxt;
            s2_za    <= s1_za;
            s2_zb    <= s1_zb;
            s2_op    <= s1_op;
            s2_tag   <= s1_tag;
        end
    end

    // Zero operands override the antilog; divide by zero raises err
    always_comb begin
        res_data = exp_q;
        res_err  = 1'b0;
        case (s2_op)
            GF_OP_DIV: begin
                if (s2_zb) begin
                    res_data = '0;
                    res_err  = 1'b1;
                end else if (s2_za) begin
                    res_data = '0;
                end
            end
`ifdef GF_INV_EN
            GF_OP_INV: begin
                if (s2_zb) begin
                    res_data = '0;
                    res_err  = 1'b1;
                end
            end
`endif
            default: begin
                if (s2_za || s2_zb) res_data = '0;
            end
        endcase
    end

    // Stage 3: output registers, held while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_tag   <= '0;
        end else if (ld3) begin
            out_valid <= s2_valid;
            out_data  <= res_data;
            out_err   <= res_err;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_gf_logmul_pipe.sv
// Directed bench for gf_logmul_pipe at M=8/POLY=11D with a second M=4/POLY=13 instance.
module tb_gf_logmul_pipe;
    import gf_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [7:0] in_a, in_b, out_data;
    gf_op_t     in_op;
    logic [3:0] in_tag, out_tag;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_err4;
    logic [3:0] in_a4, in_b4, out_data4;
    gf_op_t     in_op4;
    logic [3:0] in_tag4, out_tag4;

    int n_cmp = 0;
    int n_bad = 0;

    gf_logmul_pipe #(.M(8), .POLY(9'h11D), .TAG_W(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_tag(out_tag)
    );

    gf_logmul_pipe #(.M(4), .POLY(5'h13), .TAG_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
        .in_op(in_op4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_err(out_err4), .out_tag(out_tag4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bit-serial GF(2^8) multiply, Horner over the bits of b
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       hi;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            hi = r[7];
            r  = {r[6:0], 1'b0};
            if (hi) r = r ^ 8'h1D;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Division by exhaustive search for x with x*b == a
    function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            if (ref_mul(x, b) == a) return x;
        end
        return 8'h00;
    endfunction

    // Issue one op into an idle M=8 pipeline and collect its result and latency
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input gf_op_t op,
                          input logic [3:0] tag, output logic [7:0] d, output logic e,
                          output logic [3:0] t, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = out_data; e = out_err; t = out_tag;
    endtask

    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input gf_op_t op,
                           input logic [3:0] tag, output logic [3:0] d, output logic e,
                           output logic [3:0] t, output int lat);
        @(negedge clk);
        in_a4 = a; in_b4 = b; in_op4 = op; in_tag4 = tag; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = out_data4; e = out_err4; t = out_tag4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_err, out_tag} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b t=%h, want all 0",
                     out_valid, out_data, out_err, out_tag);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        logic [7:0] d; logic e; logic [3:0] t; int lat;
        run_op(8'h80, 8'h02, GF_OP_MUL, 4'h5, d, e, t, lat);
        n_cmp++;
        if (d !== 8'h1D) begin n_bad++; $display("FAIL mul_80_02_data: got %h want 1d", d); end
        n_cmp++;
        if (e !== 1'b0) begin n_bad++; $display("FAIL mul_80_02_err: got %b want 0", e); end
        n_cmp++;
        if (t !== 4'h5) begin n_bad++; $display("FAIL mul_80_02_tag: got %h want 5", t); end
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("FAIL mul_latency: got %0d want 3", lat); end
    endtask

    task automatic test_div_wrap();
        logic [7:0] d; logic e; logic [3:0] t; int lat;
        run_op(8'h01, 8'h02, GF_OP_DIV, 4'h6, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {8'h8E, 1'b0, 4'h6}) begin
            n_bad++; $display("FAIL div_01_02: got d=%h e=%b t=%h want 8e 0 6", d, e, t);
        end
        run_op(8'h1D, 8'h02, GF_OP_DIV, 4'h7, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {8'h80, 1'b0, 4'h7}) begin
            n_bad++; $display("FAIL div_1d_02: got d=%h e=%b t=%h want 80 0 7", d, e, t);
        end
        run_op(8'h8E, 8'h02, GF_OP_MUL, 4'h8, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {8'h01, 1'b0, 4'h8}) begin
            n_bad++; $display("FAIL mul_8e_02_wrap: got d=%h e=%b t=%h want 01 0 8", d, e, t);
        end
    endtask

    task automatic test_zero();
        logic [7:0] d; logic e; logic [3:0] t; int lat;
        run_op(8'h00, 8'h37, GF_OP_MUL, 4'h9, d, e, t, lat);
        n_cmp++;
        if ({d, e} !== {8'h00, 1'b0}) begin
            n_bad++; $display("FAIL mul_zero: got d=%h e=%b want 00 0", d, e);
        end
        run_op(8'h05, 8'h00, GF_OP_DIV, 4'hA, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {8'h00, 1'b1, 4'hA}) begin
            n_bad++; $display("FAIL div_by_zero: got d=%h e=%b t=%h want 00 1 a", d, e, t);
        end
        run_op(8'h00, 8'h05, GF_OP_DIV, 4'hB, d, e, t, lat);
        n_cmp++;
        if ({d, e} !== {8'h00, 1'b0}) begin
            n_bad++; $display("FAIL div_zero_num: got d=%h e=%b want 00 0", d, e);
        end
    endtask

`ifdef GF_INV_EN
    task automatic test_inv();
        logic [7:0] d; logic e; logic [3:0] t; int lat;
        run_op(8'h00, 8'h02, GF_OP_INV, 4'h1, d, e, t, lat);
        n_cmp++;
        if ({d, e} !== {8'h8E, 1'b0}) begin
            n_bad++; $display("FAIL inv_02: got d=%h e=%b want 8e 0", d, e);
        end
        run_op(8'h00, 8'h01, GF_OP_INV, 4'h2, d, e, t, lat);
        n_cmp++;
        if ({d, e} !== {8'h01, 1'b0}) begin
            n_bad++; $display("FAIL inv_01: got d=%h e=%b want 01 0", d, e);
        end
        run_op(8'h33, 8'h00, GF_OP_INV, 4'h3, d, e, t, lat);
        n_cmp++;
        if ({d, e} !== {8'h00, 1'b1}) begin
            n_bad++; $display("FAIL inv_00: got d=%h e=%b want 00 1", d, e);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] va [20];
        logic [7:0] vb [20];
        logic       vo [20];
        logic [7:0] qd [$];
        logic       qe [$];
        logic [3:0] qt [$];
        logic [7:0] hd, xd;
        logic       he, xe, stalled;
        logic [3:0] ht, xt;
        logic [15:0] lfsr;
        int sent, got, cyc;
        for (int i = 0; i < 20; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(1, 255));
            vo[i] = 1'($urandom_range(0, 1));
        end
        vb[5] = 8'h00; vo[5] = 1'b1;
        va[9] = 8'h00;
        vb[12] = 8'h00; vo[12] = 1'b0;
        lfsr = 16'hACE1;
        sent = 0; got = 0; cyc = 0; stalled = 1'b0;
        hd = '0; he = 1'b0; ht = '0;
        while (got < 20 && cyc < 400) begin
            @(negedge clk);
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0];
            in_valid = (sent < 20);
            if (sent < 20) begin
                in_a = va[sent]; in_b = vb[sent];
                in_op = vo[sent] ? GF_OP_DIV : GF_OP_MUL;
                in_tag = 4'(sent);
            end
            #1;
            if (stalled) begin
                n_cmp++;
                if ({out_valid, out_data, out_err, out_tag} !== {1'b1, hd, he, ht}) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b d=%h e=%b t=%h want 1 %h %b %h",
                             out_valid, out_data, out_err, out_tag, hd, he, ht);
                end
            end
            if (in_valid && in_ready) begin
                if (!vo[sent]) begin
                    qd.push_back(ref_mul(va[sent], vb[sent])); qe.push_back(1'b0);
                end else if (vb[sent] == 8'h00) begin
                    qd.push_back(8'h00); qe.push_back(1'b1);
                end else begin
                    qd.push_back(ref_div(va[sent], vb[sent])); qe.push_back(1'b0);
                end
                qt.push_back(4'(sent));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (qd.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got unexpected result d=%h t=%h", out_data, out_tag);
                end else begin
                    xd = qd.pop_front(); xe = qe.pop_front(); xt = qt.pop_front();
                    if ({out_data, out_err, out_tag} !== {xd, xe, xt}) begin
                        n_bad++;
                        $display("FAIL stream_result: got d=%h e=%b t=%h want %h %b %h",
                                 out_data, out_err, out_tag, xd, xe, xt);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            hd = out_data; he = out_err; ht = out_tag;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != 20 || sent != 20 || qd.size() != 0) begin
            n_bad++;
            $display("FAIL stream_count: got sent=%0d drained=%0d left=%0d want 20 20 0",
                     sent, got, qd.size());
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL stream_dup: got out_valid=%b after drain want 0", out_valid);
        end
    endtask

    task automatic test_stall_fill();
        int acc;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = GF_OP_MUL;
            in_a = 8'h02 << acc; in_b = 8'h02; in_tag = 4'(acc + 1);
            #1;
            if (in_ready) acc++;
        end
        n_cmp++;
        if (acc != 3) begin n_bad++; $display("FAIL stall_accepts: got %0d want 3", acc); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({out_valid, out_data, out_tag} !== {1'b1, 8'h04 << k, 4'(k + 1)}) begin
                n_bad++;
                $display("FAIL drain_%0d: got v=%b d=%h t=%h want 1 %h %h",
                         k, out_valid, out_data, out_tag, 8'h04 << k, k + 1);
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        logic [7:0] d; logic e; logic [3:0] t; int lat;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = GF_OP_MUL; in_a = 8'h11; in_b = 8'h22; in_tag = 4'(c + 12);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL inflight_pre: got %b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_err, out_tag} !== 14'h0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b d=%h e=%b t=%h want all 0",
                     out_valid, out_data, out_err, out_tag);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(8'h80, 8'h02, GF_OP_MUL, 4'h3, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {8'h1D, 1'b0, 4'h3} || lat != 3) begin
            n_bad++;
            $display("FAIL post_reset_op: got d=%h e=%b t=%h lat=%0d want 1d 0 3 lat 3", d, e, t, lat);
        end
    endtask

    task automatic test_m4();
        logic [3:0] d; logic e; logic [3:0] t; int lat;
        out_ready4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid4 = 1'b1; in_op4 = GF_OP_MUL; in_a4 = 4'h5; in_b4 = 4'h6; in_tag4 = 4'(c);
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL m4_async_reset: got %b want 0", out_valid4); end
        @(negedge clk);
        reset = 1'b0;
        run_op4(4'h8, 4'h2, GF_OP_MUL, 4'hC, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {4'h3, 1'b0, 4'hC} || lat != 3) begin
            n_bad++;
            $display("FAIL m4_mul_8_2: got d=%h e=%b t=%h lat=%0d want 3 0 c lat 3", d, e, t, lat);
        end
        run_op4(4'h3, 4'h2, GF_OP_DIV, 4'hD, d, e, t, lat);
        n_cmp++;
        if ({d, e, t} !== {4'h8, 1'b0, 4'hD}) begin
            n_bad++; $display("FAIL m4_div_3_2: got d=%h e=%b t=%h want 8 0 d", d, e, t);
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = GF_OP_MUL; in_tag = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_op4 = GF_OP_MUL; in_tag4 = '0; out_ready4 = 1'b1;
        test_reset();
        test_mul_basic();
        test_div_wrap();
        test_zero();
`ifdef GF_INV_EN
        test_inv();
`endif
        test_back_to_back();
        test_stall_fill();
        test_reset_inflight();
        test_m4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
